// File: rtl/reg_arbiter.sv
// -----------------------------------------------------------------------------
// reg_arbiter
//
// Two-requester arbiter in front of a single-ported register file. The host
// (SPI side) and the aux requester (internal modulation/sweep engine) each
// present one transaction at a time. The arbiter issues the winner's access to
// the register file for exactly one cycle (GRANT). It then spends one cycle in
// RESP returning read data. Peak throughput is one transaction per two cycles.
//
// Handshake: a requester raises *_req_i with we/addr/wdata stable and holds
// them until it sees its *_gnt_o pulse. Its request is consumed on the clock
// edge that ends that pulse. For a read, *_rvalid_o pulses one cycle later
// with *_rdata_o. Dropping *_req_i before the grant withdraws the request.
//
// Arbitration:
//   default            : host wins on contention unless aux has lost
//                        STARVE_LIMIT times in a row; then aux wins once.
//   REG_ARB_RR_EN      : round-robin; on contention the port not granted
//                        last wins, host preferred after reset.
//
// Parameters:
//   STARVE_LIMIT (1..7) consecutive aux losses before aux is forced to win
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   host_req_i/we_i/addr_i/wdata_i    host request
//   host_gnt_o/rvalid_o/rdata_o       host grant pulse, read response
//   aux_req_i/we_i/addr_i/wdata_i     aux request
//   aux_gnt_o/rvalid_o/rdata_o        aux grant pulse, read response
//   reg_addr_o/wdata_o/we_o           register file access (valid in GRANT)
//   reg_rdata_i                       register file combinational read data
//
// The FSM state is held in the signal `state` for observation by checkers.
// -----------------------------------------------------------------------------
module reg_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       host_req_i,
  input  logic       host_we_i,
  input  logic [6:0] host_addr_i,
  input  logic [7:0] host_wdata_i,
  output logic       host_gnt_o,
  output logic       host_rvalid_o,
  output logic [7:0] host_rdata_o,
  input  logic       aux_req_i,
  input  logic       aux_we_i,
  input  logic [6:0] aux_addr_i,
  input  logic [7:0] aux_wdata_i,
  output logic       aux_gnt_o,
  output logic       aux_rvalid_o,
  output logic [7:0] aux_rdata_o,
  output logic [6:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  input  logic [7:0] reg_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t state;

  // Winner of the transaction currently in GRANT/RESP.
  logic win_aux;
  logic win_we;

  logic any_req;
  logic both_req;
  logic pick_aux;
  logic       sel_we;
  logic [6:0] sel_addr;
  logic [7:0] sel_wdata;

  assign any_req  = host_req_i | aux_req_i;
  assign both_req = host_req_i & aux_req_i;

`ifdef REG_ARB_RR_EN
  // Set when aux should win the next contended arbitration.
  logic prefer_aux;

  always_comb begin
    pick_aux = aux_req_i;
    if (both_req) pick_aux = prefer_aux;
  end
`else
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt;
  logic [2:0] starve_next;

  always_comb begin
    pick_aux = aux_req_i;
    if (both_req) pick_aux = (starve_cnt == LIMIT);
  end

  // Counts only contended host wins. Any arbitration where aux is absent,
  // including a withdrawn aux request, or where aux wins restarts the count.
  always_comb begin
    starve_next = 3'd0;
    if (aux_req_i && !pick_aux) begin
      if (starve_cnt < LIMIT) starve_next = starve_cnt + 3'd1;
      else                    starve_next = starve_cnt;
    end
  end
`endif

  always_comb begin
    sel_we    = host_we_i;
    sel_addr  = host_addr_i;
    sel_wdata = host_wdata_i;
    if (pick_aux) begin
      sel_we    = aux_we_i;
      sel_addr  = aux_addr_i;
      sel_wdata = aux_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      win_aux       <= 1'b0;
      win_we        <= 1'b0;
      host_gnt_o    <= 1'b0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= 8'h00;
      aux_gnt_o     <= 1'b0;
      aux_rvalid_o  <= 1'b0;
      aux_rdata_o   <= 8'h00;
      reg_addr_o    <= 7'h00;
      reg_wdata_o   <= 8'h00;
      reg_we_o      <= 1'b0;
`ifdef REG_ARB_RR_EN
      prefer_aux    <= 1'b0;
`else
      starve_cnt    <= 3'd0;
`endif
    end else begin
      case (state)
        // IDLE and RESP both arbitrate. That lets back-to-back requests
        // run at one transaction every two cycles.
        S_IDLE, S_RESP: begin
          host_rvalid_o <= 1'b0;
          aux_rvalid_o  <= 1'b0;
`ifndef REG_ARB_RR_EN
          starve_cnt    <= starve_next;
`endif
          if (any_req) begin
            state       <= S_GRANT;
            win_aux     <= pick_aux;
            win_we      <= sel_we;
            reg_addr_o  <= sel_addr;
            reg_wdata_o <= sel_wdata;
            reg_we_o    <= sel_we;
            host_gnt_o  <= ~pick_aux;
            aux_gnt_o   <= pick_aux;
`ifdef REG_ARB_RR_EN
            prefer_aux  <= ~pick_aux;
`endif
          end else begin
            state <= S_IDLE;
          end
        end

        // Register file read data is combinational on reg_addr_o, so it is
        // captured at the end of the single GRANT cycle.
        S_GRANT: begin
          host_gnt_o <= 1'b0;
          aux_gnt_o  <= 1'b0;
          reg_we_o   <= 1'b0;
          if (!win_we) begin
            if (win_aux) begin
              aux_rdata_o  <= reg_rdata_i;
              aux_rvalid_o <= 1'b1;
            end else begin
              host_rdata_o  <= reg_rdata_i;
              host_rvalid_o <= 1'b1;
            end
          end
          state <= S_RESP;
        end

        default: begin
          host_gnt_o    <= 1'b0;
          aux_gnt_o     <= 1'b0;
          reg_we_o      <= 1'b0;
          host_rvalid_o <= 1'b0;
          aux_rvalid_o  <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule
